// File: rtl/rxd_router_pkg.sv
// Shared types, header tag and oversample-divider helper for the rxd_router receive path.
package rxd_router_pkg;

  localparam logic [6:0] HDR_TAG = 7'b1010000;

  typedef enum logic {
    IDLE,
    PAYLOAD
  } parse_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Rounded clocks per 16x oversample tick.
  function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
    return (clk_freq + 8 * baud) / (16 * baud);
  endfunction

endpackage

// File: rtl/rxd_router_if.sv
// Two-channel consumer bus: per-channel payload byte with one-deep valid/ack handshake.
interface rxd_router_if;
  logic [15:0] Data;
  logic [1:0]  Valid;
  logic [1:0]  Ack;

  modport master (output Data, output Valid, input Ack);
  modport slave  (input Data, input Valid, output Ack);
endinterface

// File: rtl/rxd_router_uart_rx_core.sv
// uart_rx_core: 8N1 receiver with 2-FF synchronizer, 16x oversampling, byte strobe and frame-error pulse.
module uart_rx_core
  import rxd_router_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sdi,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_error
);
  localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_div_check
    $error("uart_rx_core: oversample divider must be >= 1");
  end

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  rx_state_e        state_q, state_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             armed_q, armed_d;
  logic             strobe_q, strobe_d;
  logic             ferr_q, ferr_d;
  logic             tick_c;
  logic             rx_c;

  assign tick_c      = (div_cnt_q == DIV_W'(DIV - 1));
  assign rx_c        = sync2_q;
  assign rx_byte     = shift_q;
  assign rx_strobe   = strobe_q;
  assign frame_error = ferr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      div_cnt_q  <= '0;
      state_q    <= RX_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      armed_q    <= 1'b0;
      strobe_q   <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      div_cnt_q  <= div_cnt_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      armed_q    <= armed_d;
      strobe_q   <= strobe_d;
      ferr_q     <= ferr_d;
    end
  end

  // Frames start only once armed, i.e. after the line was seen high on a tick.
  always_comb begin
    sync1_d    = sdi;
    sync2_d    = sync1_q;
    div_cnt_d  = tick_c ? '0 : div_cnt_q + 1'b1;
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    strobe_d   = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (armed_q && !rx_c) begin
          state_d    = RX_START;
          tick_cnt_d = '0;
          armed_d    = 1'b0;
        end else if (tick_c && rx_c) begin
          armed_d = 1'b1;
        end
      end
      RX_START: begin
        if (tick_c) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            if (rx_c) begin
              state_d = RX_IDLE;
              armed_d = 1'b1;
            end else begin
              state_d = RX_DATA;
            end
          end
        end
      end
      RX_DATA: begin
        if (tick_c) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = '0;
            shift_d    = {rx_c, shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick_c) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = '0;
            state_d    = RX_IDLE;
            if (rx_c) begin
              strobe_d = 1'b1;
              armed_d  = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/rxd_router.sv
// rxd_router: parses 2-byte UART packets (header, payload) into two one-deep consumer channels.
// Optional payload timeout is compiled in with RXD_ROUTER_TIMEOUT_EN.
module rxd_router
  import rxd_router_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               SDI,
  rxd_router_if.master       out_if,
  output logic               FrameError,
  output logic               Dropped,
  output logic [1:0]         Overrun
);
  if (TIMEOUT_BITS < 1) begin : g_timeout_check
    $error("rxd_router: TIMEOUT_BITS must be >= 1");
  end

  logic [7:0]   rx_byte;
  logic         rx_strobe;
  logic         frame_err;

  parse_state_e state_q, state_d;
  logic         ch_q, ch_d;
  logic [15:0]  data_q, data_d;
  logic [1:0]   valid_q, valid_d;
  logic         dropped_q, dropped_d;
  logic [1:0]   overrun_q, overrun_d;

  uart_rx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_core (
    .clk         (Clock),
    .rst         (Reset),
    .sdi         (SDI),
    .rx_byte     (rx_byte),
    .rx_strobe   (rx_strobe),
    .frame_error (frame_err)
  );

`ifdef RXD_ROUTER_TIMEOUT_EN
  localparam int unsigned DIV      = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TO_LIMIT = 16 * TIMEOUT_BITS;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             tick_c;

  assign tick_c = (div_cnt_q == DIV_W'(DIV - 1));

  // Local oversample tick so the timeout counts in the same units as the receiver.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      div_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      ch_q      <= 1'b0;
      data_q    <= '0;
      valid_q   <= '0;
      dropped_q <= 1'b0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
      overrun_q <= overrun_d;
    end
  end

  // Ack clears first so a same-cycle load on that channel wins and keeps Valid high.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    data_d    = data_q;
    valid_d   = valid_q & ~out_if.Ack;
    dropped_d = 1'b0;
    overrun_d = '0;
`ifdef RXD_ROUTER_TIMEOUT_EN
    div_cnt_d = tick_c ? '0 : div_cnt_q + 1'b1;
    to_cnt_d  = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_strobe) begin
          if (rx_byte[7:1] == HDR_TAG) begin
            ch_d    = rx_byte[0];
            state_d = PAYLOAD;
`ifdef RXD_ROUTER_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end else begin
            dropped_d = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (rx_strobe) begin
          state_d = IDLE;
          if (!valid_q[ch_q] || out_if.Ack[ch_q]) begin
            if (ch_q) data_d[15:8] = rx_byte;
            else      data_d[7:0]  = rx_byte;
            valid_d[ch_q] = 1'b1;
          end else begin
            overrun_d[ch_q] = 1'b1;
          end
        end else if (frame_err) begin
          state_d = IDLE;
        end
`ifdef RXD_ROUTER_TIMEOUT_EN
        else if (tick_c) begin
          if (to_cnt_q == TO_W'(TO_LIMIT - 1)) begin
            dropped_d = 1'b1;
            state_d   = IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
`endif
      end
    endcase
  end

  assign out_if.Data  = data_q;
  assign out_if.Valid = valid_q;
  assign FrameError   = frame_err;
  assign Dropped      = dropped_q;
  assign Overrun      = overrun_q;

endmodule

// File: doc/rxd_router.md
# rxd_router

Receive-side counterpart of the two-client UART transmit arbiter. Deserializes 8N1 UART bytes from the serial input, parses 2-byte packets (header, payload), and delivers each payload to one of two consumer channels through a one-deep valid/ack holding register per channel. Sits between the board serial input pin and the two internal command consumers.

## Interface
- CLK_FREQ, 100_000_000: Clock frequency in Hz.
- BAUD, 115200: Serial bit rate.
- TIMEOUT_BITS, 40: Bit periods allowed between header stop bit and payload stop bit. Used only when the timeout feature is compiled in.
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- SDI  in  1  asynchronous serial input; idles high.
- Data  out  16  channel 1 payload on [15:8], channel 0 payload on [7:0].
- Valid  out  2  Valid[c] high while Data for channel c holds an unconsumed byte.
- Ack  in  2  Ack[c] high for one cycle consumes channel c; ignored while Valid[c] is low.
- FrameError  out  1  one-cycle pulse when a stop bit samples 0.
- Dropped  out  1  one-cycle pulse when a byte is discarded by the parser: bad header or timeout.
- Overrun  out  2  one-cycle pulse per channel when a payload arrives while that channel is full.

## Operation
- Outputs after reset: Data=0, Valid=0, FrameError=0, Dropped=0, Overrun=0. Parser is in IDLE and the receiver core is idle.
- Oversample tick period is DIV = round(CLK_FREQ/(16·BAUD)) clocks. DIV must be ≥1; elaboration fails otherwise.
- SDI passes through a 2-FF synchronizer whose flops reset to 1.
- Receiver core:
  - A high-to-low edge on the synchronized line starts a frame.
  - Start bit is re-checked at sample 8. If it reads high, the frame is treated as a glitch and the core returns to idle with no output.
  - Data bits are sampled at the mid-bit point (every 16 ticks), LSB first.
  - If the stop bit samples 1, the core emits a one-cycle byte strobe plus the byte.
  - If the stop bit samples 0, the core pulses FrameError, discards the byte, and re-arms only after the line has been high for one tick.
- Parser FSM:
  - IDLE, on byte b: if b[7:1] = 7'b1010000, latch ch = b[0] and go to PAYLOAD. Otherwise pulse Dropped and stay in IDLE.
  - PAYLOAD, on byte p: if Valid[ch]=0, or Ack[ch]=1 in the same cycle, load p into Data[8·ch+:8] and set Valid[ch]=1. Otherwise pulse Overrun[ch]; the stored byte is kept. Return to IDLE in either case.
  - PAYLOAD, on FrameError: return to IDLE. Dropped is not pulsed.
- Ack[c] with Valid[c]=1 clears Valid[c] on the next edge. Data is not cleared.
- Load and Ack on the same channel in the same cycle: the new byte is stored and Valid stays 1.
- Both channels operate independently. A load on one channel and an Ack on the other in the same cycle are both honoured.

## Timing
- Valid[ch] rises on the first edge after the payload byte strobe. This is 1 cycle after the stop-bit mid-sample.
- Total latency from the payload stop-bit mid-sample to Valid: 2 cycles, including the strobe register.
- FrameError, Dropped, and Overrun are single-cycle pulses, asserted the cycle after the byte strobe or stop sample.
- Ack is sampled on every edge; the consumer may hold Ack for at most one cycle per byte.
- Reset asserted mid-frame aborts the frame. After reset is released, the core will not start a frame until the synchronized line has been high for at least one tick.

## Configuration
- RXD_ROUTER_TIMEOUT_EN defined:
  - In PAYLOAD, count oversample ticks.
  - At 16·TIMEOUT_BITS ticks with no payload strobe, pulse Dropped and return to IDLE.
  - The count clears on entry to PAYLOAD.
- RXD_ROUTER_TIMEOUT_EN undefined: no counter; PAYLOAD waits indefinitely. TIMEOUT_BITS is unused.

## Structure
- Shared package rxd_router_pkg holds:
  - header constant HDR_TAG = 7'b1010000;
  - the parser state typedef (IDLE, PAYLOAD);
  - the function computing DIV from CLK_FREQ and BAUD.
- Sub-module uart_rx_core contains the synchronizer, oversample divider, bit FSM (IDLE, START, DATA, STOP), byte strobe, and FrameError. The router top contains only the parser, holding registers, and timeout.

## Test plan
- Bench settings CLK_FREQ=16_000_000, BAUD=1_000_000 (DIV=1, 16 clocks per bit). Send 0xA1 then 0x5A → Valid=2'b10 and Data[15:8]=0x5A, 2 cycles after the stop mid-sample; Ack[1] pulse → Valid=2'b00 next cycle.
- Send 0xA0,0x11 then 0xA0,0x22 with no Ack → Data[7:0]=0x11 retained; Overrun[0] pulses once.
- Header 0x3C → Dropped pulses and Valid is unchanged. A following 0xA0,0x77 → Data[7:0]=0x77 and Valid[0]=1.
- 0xA1 header, then a payload with stop bit forced 0 → FrameError pulses, parser returns to IDLE, Valid[1] stays 0. Next 0xA1,0x01 is delivered.
- With RXD_ROUTER_TIMEOUT_EN and TIMEOUT_BITS=40: send 0xA0, then idle for 641 clocks → Dropped pulses. A late byte 0x55 is then treated as a header and also produces Dropped.
- Assert Reset during bit 3 of a byte, release it, then send 0xA1,0xC3 → all outputs are 0 during reset and the packet is delivered correctly afterwards.
